// File: rtl/fb_fetch_arbiter_pkg.sv
// fb_fetch_arbiter_pkg: shared state encoding, bus widths and row address helper
// Rev 1.0
`default_nettype none

package fb_fetch_arbiter_pkg;

  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 32;
  localparam int LBUF_AW = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // Word address of a row element; wraps naturally to the 18-bit bus.
  function automatic logic [ADDR_W-1:0] row_addr(
    input logic [ADDR_W-1:0] y,
    input logic [ADDR_W-1:0] words,
    input logic [ADDR_W-1:0] w
  );
    return y * words + w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fb_fetch_arbiter.sv
// fb_fetch_arbiter: shares one memory port between row prefetch into a
// double-buffered line buffer and CPU writes. Rev 1.0
`default_nettype none

module fb_fetch_arbiter
  import fb_fetch_arbiter_pkg::*;
#(
  parameter  int WORDS_PER_LINE = 80,
  parameter  int CPU_SLOT       = 16,
  parameter  int NUM_ROWS       = 480,
  localparam int Y_W            = $clog2(NUM_ROWS),
  localparam int SLOT_W         = $clog2(CPU_SLOT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_line_start,
  input  logic [Y_W-1:0]     i_line_y,
  input  logic               i_cpu_valid,
  input  logic [ADDR_W-1:0]  i_cpu_addr,
  input  logic [DATA_W-1:0]  i_cpu_wdata,
  output logic               o_cpu_ready,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic [DATA_W-1:0]  o_mem_wdata,
  input  logic [DATA_W-1:0]  i_mem_rdata,
  input  logic               i_mem_ack,
  output logic               o_lbuf_we,
  output logic [LBUF_AW-1:0] o_lbuf_waddr,
  output logic [DATA_W-1:0]  o_lbuf_wdata,
  output logic               o_lbuf_bank,
  output logic               o_underrun
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_pending;
  logic                r_restart;
  logic                r_underrun;
  logic                r_bank;
  logic                r_lbuf_we;
  logic [Y_W-1:0]      r_line_y;
  logic [Y_W-1:0]      r_new_y;
  logic [LBUF_AW-1:0]  r_word_cnt;
  logic [LBUF_AW-1:0]  r_lbuf_waddr;
  logic [DATA_W-1:0]   r_lbuf_wdata;
  logic [SLOT_W-1:0]   r_slot_cnt;
  logic [SLOT_W-1:0]   w_slot_inc;
  logic                w_slot_hit;
  logic                w_last;
  logic                w_restart_now;
  logic [ADDR_W-1:0]   w_fetch_addr;

  assign w_last        = (r_word_cnt == LBUF_AW'(WORDS_PER_LINE - 1));
  assign w_slot_inc    = (r_slot_cnt == SLOT_W'(CPU_SLOT)) ? r_slot_cnt : r_slot_cnt + 1'b1;
  assign w_slot_hit    = (w_slot_inc == SLOT_W'(CPU_SLOT));
  // A new row arriving mid-fetch restarts the fetch, unless it lands on the final ack.
  assign w_restart_now = r_restart || (i_line_start && !w_last);
  assign w_fetch_addr  = row_addr(ADDR_W'(r_line_y), ADDR_W'(WORDS_PER_LINE), ADDR_W'(r_word_cnt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (r_pending)        w_state_nxt = ST_FETCH;
        else if (i_cpu_valid) w_state_nxt = ST_WRITE;
      end
      ST_FETCH: begin
        if (i_mem_ack) begin
          if (w_restart_now)                  w_state_nxt = ST_FETCH;
          else if (w_last)                    w_state_nxt = ST_IDLE;
          else if (w_slot_hit && i_cpu_valid) w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (i_mem_ack) w_state_nxt = (r_pending || i_line_start) ? ST_FETCH : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_cpu_ready = 1'b0;
    unique case (r_state)
      ST_FETCH: begin
        o_mem_req  = 1'b1;
        o_mem_addr = w_fetch_addr;
      end
      ST_WRITE: begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = i_cpu_addr;
        o_mem_wdata = i_cpu_wdata;
        o_cpu_ready = i_mem_ack;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending    <= 1'b0;
      r_restart    <= 1'b0;
      r_underrun   <= 1'b0;
      r_bank       <= 1'b0;
      r_lbuf_we    <= 1'b0;
      r_line_y     <= '0;
      r_new_y      <= '0;
      r_word_cnt   <= '0;
      r_lbuf_waddr <= '0;
      r_lbuf_wdata <= '0;
      r_slot_cnt   <= '0;
    end else begin
      r_lbuf_we <= 1'b0;
      if (r_state == ST_FETCH) begin
        if (i_mem_ack) begin
          r_lbuf_we    <= 1'b1;
          r_lbuf_waddr <= r_word_cnt;
          r_lbuf_wdata <= i_mem_rdata;
          if (w_restart_now) begin
            r_line_y   <= i_line_start ? i_line_y : r_new_y;
            r_word_cnt <= '0;
            r_slot_cnt <= '0;
            r_restart  <= 1'b0;
            r_underrun <= 1'b1;
          end else if (w_last) begin
            r_bank     <= ~r_bank;
            r_word_cnt <= '0;
            r_slot_cnt <= '0;
            r_pending  <= i_line_start;
            if (i_line_start) r_line_y <= i_line_y;
          end else begin
            r_word_cnt <= r_word_cnt + 1'b1;
            r_slot_cnt <= (w_slot_hit && i_cpu_valid) ? '0 : w_slot_inc;
          end
        end else if (i_line_start) begin
          // The outstanding read must finish on its old address before switching rows.
          r_restart  <= 1'b1;
          r_new_y    <= i_line_y;
          r_underrun <= 1'b1;
        end
      end else if (i_line_start) begin
        r_line_y   <= i_line_y;
        r_word_cnt <= '0;
        r_slot_cnt <= '0;
        r_pending  <= 1'b1;
        if (r_pending) r_underrun <= 1'b1;
      end
    end
  end

  assign o_lbuf_we    = r_lbuf_we;
  assign o_lbuf_waddr = r_lbuf_waddr;
  assign o_lbuf_wdata = r_lbuf_wdata;
  assign o_lbuf_bank  = r_bank;
  assign o_underrun   = r_underrun;

endmodule

`default_nettype wire
